// File: rtl/rssi_cca_detect_if.sv
// Averaged RSSI sample stream from the IQ-magnitude averaging path into the CCA detector.
// One sample per iq_rssi_valid cycle; there is no ready signal because the consumer never stalls.
interface rssi_cca_detect_if #(
    parameter int IQ_DATA_WIDTH = 16
);
    logic signed [IQ_DATA_WIDTH-1:0] iq_rssi;
    logic                            iq_rssi_valid;

    modport master (output iq_rssi, output iq_rssi_valid);
    modport slave  (input  iq_rssi, input  iq_rssi_valid);
endinterface

// File: rtl/rssi_cca_detect.sv
// Hysteresis clear-channel detector on the RSSI stream, with peak/length capture per busy period.
// ch_busy follows the deciding valid sample by one cycle; every valid sample is accepted, no backpressure.
module rssi_cca_detect #(
    parameter int IQ_DATA_WIDTH = 16,
    parameter int CNT_WIDTH     = 12
) (
    input  logic                            clk,
    input  logic                            rstn,
    rssi_cca_detect_if.slave                rssi,
    input  logic                            cfg_enable,
    input  logic signed [IQ_DATA_WIDTH-1:0] cfg_thres_high,
    input  logic signed [IQ_DATA_WIDTH-1:0] cfg_thres_low,
    input  logic        [CNT_WIDTH-1:0]     cfg_assert_len,
    input  logic        [CNT_WIDTH-1:0]     cfg_deassert_len,
    output logic                            ch_busy,
    output logic                            ch_busy_rise,
    output logic                            ch_busy_fall,
    output logic        [CNT_WIDTH-1:0]     busy_len,
    output logic signed [IQ_DATA_WIDTH-1:0] rssi_peak
);
    typedef enum logic [1:0] {IDLE, ARM, BUSY, RELEASE} state_t;

    state_t                          state;
    logic        [CNT_WIDTH-1:0]     cnt;
    logic signed [IQ_DATA_WIDTH-1:0] sample;
    logic                            ge_high;
    logic                            lt_low;
    logic        [CNT_WIDTH:0]       cnt_inc;
    logic                            assert_done;
    logic                            release_done;
    logic        [CNT_WIDTH-1:0]     busy_len_inc;
    logic signed [IQ_DATA_WIDTH-1:0] peak_max;

    assign sample  = rssi.iq_rssi;
    assign ge_high = sample >= cfg_thres_high;
    assign lt_low  = sample < cfg_thres_low;

    // cnt is 0 in IDLE and BUSY, so the same ">=" test covers the len<=1 shortcut
    // and the case where the length was lowered below an in-progress count.
    assign cnt_inc      = {1'b0, cnt} + (CNT_WIDTH+1)'(1);
    assign assert_done  = cnt_inc >= {1'b0, cfg_assert_len};
    assign release_done = cnt_inc >= {1'b0, cfg_deassert_len};

    assign busy_len_inc = (&busy_len) ? busy_len : busy_len + CNT_WIDTH'(1);
    assign peak_max     = (sample > rssi_peak) ? sample : rssi_peak;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            cnt          <= '0;
            ch_busy      <= 1'b0;
            ch_busy_rise <= 1'b0;
            ch_busy_fall <= 1'b0;
            busy_len     <= '0;
            rssi_peak    <= '0;
        end else begin
            ch_busy_rise <= 1'b0;
            ch_busy_fall <= 1'b0;
            if (!cfg_enable) begin
                state        <= IDLE;
                cnt          <= '0;
                ch_busy      <= 1'b0;
                ch_busy_fall <= ch_busy;
            end else if (rssi.iq_rssi_valid) begin
                case (state)
                    IDLE, ARM: begin
                        if (!ge_high) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (assert_done) begin
                            state        <= BUSY;
                            cnt          <= '0;
                            ch_busy      <= 1'b1;
                            ch_busy_rise <= 1'b1;
                            busy_len     <= CNT_WIDTH'(1);
                            rssi_peak    <= sample;
                        end else begin
                            state <= ARM;
                            cnt   <= cnt_inc[CNT_WIDTH-1:0];
                        end
                    end
                    BUSY, RELEASE: begin
                        if (lt_low && release_done) begin
                            // exiting sample is not part of the busy period statistics
                            state        <= IDLE;
                            cnt          <= '0;
                            ch_busy      <= 1'b0;
                            ch_busy_fall <= 1'b1;
                        end else begin
                            state     <= lt_low ? RELEASE : BUSY;
                            cnt       <= lt_low ? cnt_inc[CNT_WIDTH-1:0] : '0;
                            busy_len  <= busy_len_inc;
                            rssi_peak <= peak_max;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rssi_cca_detect.sv
// Scoreboard bench for rssi_cca_detect: a run-length reference model predicts every cycle's outputs.
module tb_rssi_cca_detect;
    localparam int W  = 16;
    localparam int CW = 12;

    typedef struct packed {
        logic                busy;
        logic                rise;
        logic                fall;
        logic [CW-1:0]       len;
        logic signed [W-1:0] peak;
    } exp_t;

    logic                clk = 1'b0;
    logic                rstn;
    logic                cfg_enable;
    logic signed [W-1:0] cfg_thres_high;
    logic signed [W-1:0] cfg_thres_low;
    logic [CW-1:0]       cfg_assert_len;
    logic [CW-1:0]       cfg_deassert_len;
    logic                ch_busy;
    logic                ch_busy_rise;
    logic                ch_busy_fall;
    logic [CW-1:0]       busy_len;
    logic signed [W-1:0] rssi_peak;

    int vectors     = 0;
    int miscompares = 0;

    exp_t exp_q[$];

    // reference model state: busy flag plus run length of qualifying samples
    bit m_busy, m_rise, m_fall;
    int m_run, m_len, m_peak;

    rssi_cca_detect_if #(.IQ_DATA_WIDTH(W)) rssi_if ();

    rssi_cca_detect #(.IQ_DATA_WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .rssi             (rssi_if),
        .cfg_enable       (cfg_enable),
        .cfg_thres_high   (cfg_thres_high),
        .cfg_thres_low    (cfg_thres_low),
        .cfg_assert_len   (cfg_assert_len),
        .cfg_deassert_len (cfg_deassert_len),
        .ch_busy          (ch_busy),
        .ch_busy_rise     (ch_busy_rise),
        .ch_busy_fall     (ch_busy_fall),
        .busy_len         (busy_len),
        .rssi_peak        (rssi_peak)
    );

    always #5 clk = ~clk;

    task automatic model_step(input logic v, input int x);
        int need;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (!rstn) begin
            m_busy = 1'b0; m_run = 0; m_len = 0; m_peak = 0;
        end else if (!cfg_enable) begin
            m_fall = m_busy;
            m_busy = 1'b0;
            m_run  = 0;
        end else if (v) begin
            if (!m_busy) begin
                m_run = (x >= int'(cfg_thres_high)) ? m_run + 1 : 0;
                need  = (cfg_assert_len == 0) ? 1 : int'(cfg_assert_len);
                if (m_run >= need) begin
                    m_busy = 1'b1; m_rise = 1'b1; m_run = 0; m_len = 1; m_peak = x;
                end
            end else begin
                m_run = (x < int'(cfg_thres_low)) ? m_run + 1 : 0;
                need  = (cfg_deassert_len == 0) ? 1 : int'(cfg_deassert_len);
                if (m_run >= need) begin
                    m_busy = 1'b0; m_fall = 1'b1; m_run = 0;
                end else begin
                    m_len  = (m_len + 1 > 4095) ? 4095 : m_len + 1;
                    m_peak = (x > m_peak) ? x : m_peak;
                end
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.busy = m_busy;
        e.rise = m_rise;
        e.fall = m_fall;
        e.len  = CW'(m_len);
        e.peak = W'(m_peak);
        return e;
    endfunction

    // Called at a falling edge: drive one cycle of stimulus, predict, then move to the next falling edge.
    task automatic step(input logic v, input int x);
        rssi_if.iq_rssi_valid = v;
        rssi_if.iq_rssi       = W'(x);
        model_step(v, x);
        exp_q.push_back(model_out());
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int got, input int want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic do_reset();
        rstn                  = 1'b0;
        rssi_if.iq_rssi_valid = 1'b0;
        rssi_if.iq_rssi       = '0;
        #1;
        chk("rst_busy", int'(ch_busy), 0);
        chk("rst_pulses", int'({ch_busy_rise, ch_busy_fall}), 0);
        chk("rst_len", int'(busy_len), 0);
        chk("rst_peak", int'(rssi_peak), 0);
        model_step(1'b0, 0);
        exp_q.push_back(model_out());
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic set_cfg(input int hi, input int lo, input int al, input int dl);
        cfg_thres_high   = W'(hi);
        cfg_thres_low    = W'(lo);
        cfg_assert_len   = CW'(al);
        cfg_deassert_len = CW'(dl);
    endtask

    // Monitor: every cycle the DUT presents a new output word, compared against the queued prediction.
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = '{ch_busy, ch_busy_rise, ch_busy_fall, busy_len, rssi_peak};
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL cycle t=%0t got busy=%b rise=%b fall=%b len=%0d peak=%0d expected busy=%b rise=%b fall=%b len=%0d peak=%0d",
                             $time, got.busy, got.rise, got.fall, got.len, got.peak,
                             e.busy, e.rise, e.fall, e.len, e.peak);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rstn                  = 1'b0;
        cfg_enable            = 1'b1;
        rssi_if.iq_rssi_valid = 1'b0;
        rssi_if.iq_rssi       = '0;
        set_cfg(100, 80, 4, 3);
        m_busy = 0; m_rise = 0; m_fall = 0; m_run = 0; m_len = 0; m_peak = 0;

        @(negedge clk);
        chk("reset_busy", int'(ch_busy), 0);
        chk("reset_len", int'(busy_len), 0);
        chk("reset_peak", int'(rssi_peak), 0);
        rstn = 1'b1;

        // assert dwell broken by a low sample
        step(1, 120); step(1, 120); step(1, 120); step(1, 50);
        chk("broken_run_busy", int'(ch_busy), 0);

        // full assert dwell
        step(1, 120); step(1, 120); step(1, 120);
        chk("dwell_before_busy", int'(ch_busy), 0);
        step(1, 120);
        chk("dwell_busy", int'(ch_busy), 1);
        chk("dwell_rise", int'(ch_busy_rise), 1);
        chk("dwell_len", int'(busy_len), 1);
        step(0, 0);
        chk("rise_one_cycle", int'(ch_busy_rise), 0);

        // hysteresis
        step(1, 90); step(1, 70); step(1, 70); step(1, 90);
        chk("hyst_still_busy", int'(ch_busy), 1);
        step(1, 70); step(1, 70);
        chk("hyst_before_fall", int'(ch_busy), 1);
        step(1, 70);
        chk("hyst_fall", int'(ch_busy_fall), 1);
        chk("hyst_len", int'(busy_len), 7);
        chk("hyst_peak", int'(rssi_peak), 120);

        // peak and length
        set_cfg(100, 80, 1, 3);
        step(1, 120); step(1, 300); step(1, 150); step(1, 70); step(1, 70); step(1, 70);
        chk("peak_fall", int'(ch_busy_fall), 1);
        step(0, 0); step(1, 10); step(0, 0);
        chk("peak_hold_len", int'(busy_len), 5);
        chk("peak_hold_peak", int'(rssi_peak), 300);

        // sparse valid
        set_cfg(100, 80, 4, 1);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) chk("sparse_before", int'(ch_busy), 0);
            step(1, 120);
            if (i < 3) begin step(0, 0); step(0, 0); step(0, 0); end
        end
        chk("sparse_busy", int'(ch_busy), 1);
        step(1, 0);
        chk("sparse_release", int'(ch_busy), 0);

        // zero and unit dwell
        set_cfg(100, 80, 0, 1);
        step(1, 100);
        chk("alen0_busy", int'(ch_busy), 1);
        step(1, 0);
        set_cfg(100, 80, 1, 1);
        step(1, 100);
        chk("alen1_busy", int'(ch_busy), 1);
        step(1, 0);

        // enable drop mid-busy
        step(1, 200);
        cfg_enable = 1'b0;
        step(1, 500);
        chk("en_drop_busy", int'(ch_busy), 0);
        chk("en_drop_fall", int'(ch_busy_fall), 1);
        chk("en_drop_peak", int'(rssi_peak), 200);
        cfg_enable = 1'b1;

        // reset mid-ARM
        set_cfg(100, 80, 4, 3);
        step(1, 120); step(1, 120);
        do_reset();
        step(1, 120);
        chk("post_reset_busy", int'(ch_busy), 0);

        // busy_len saturation: nothing ever falls below the minimum threshold
        set_cfg(-32768, -32768, 1, 2);
        for (int i = 0; i < 4100; i++) step(1, int'($urandom_range(600)) - 300);
        chk("sat_len", int'(busy_len), 4095);
        cfg_enable = 1'b0;
        step(0, 0);
        cfg_enable = 1'b1;

        // randomized traffic with config churn, including low > high
        for (int i = 0; i < 2500; i++) begin
            if (i % 200 == 0 || $urandom_range(49) == 0)
                set_cfg(int'($urandom_range(200)) - 50, int'($urandom_range(200)) - 50,
                        int'($urandom_range(5)), int'($urandom_range(5)));
            cfg_enable = ($urandom_range(40) != 0);
            if ($urandom_range(499) == 0) do_reset();
            step($urandom_range(2) != 0, int'($urandom_range(400)) - 100);
        end

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d predictions left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
